// File: rtl/video_cfg_pkg.sv
// ============================================================================
// Module      : video_cfg_pkg
// Description : Shared states, command codes, register map and defaults
//               for the video configuration controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package video_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      OSD     = 3'd2,
      ADDR    = 3'd3,
      DATA    = 3'd4,
      DISCARD = 3'd5
   } state_t;

   localparam logic [7:0] CMD_OSD = 8'h01;
   localparam logic [7:0] CMD_CFG = 8'h02;

   localparam logic [2:0] REG_SCANLINES = 3'd0;
   localparam logic [2:0] REG_VOLUME    = 3'd1;
   localparam logic [2:0] REG_WIDE      = 3'd2;
   localparam logic [2:0] REG_NTSC      = 3'd3;
   localparam logic [2:0] REG_AUDIO_LO  = 3'd4;
   localparam logic [2:0] REG_AUDIO_HI  = 3'd5;

   localparam logic [1:0] DEFAULT_SCANLINES = 2'd0;
   localparam logic [1:0] DEFAULT_VOLUME    = 2'd3;
   localparam logic [8:0] DEFAULT_AUDIO_DIV = 9'd327;

   function automatic state_t cmd_next(input logic [7:0] cmd);
      case (cmd)
         CMD_OSD: cmd_next = OSD;
         CMD_CFG: cmd_next = ADDR;
         default: cmd_next = DISCARD;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/video_cfg_regs.sv
// ============================================================================
// Module      : video_cfg_regs
// Description : Shadow/active configuration registers with atomic commit.
//               Build option VIDEO_CFG_VSYNC_COMMIT_EN defers commit to vsync.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_cfg_regs
   import video_cfg_pkg::*;
#(
   parameter logic [1:0] DEF_SCANLINES = DEFAULT_SCANLINES,
   parameter logic [1:0] DEF_VOLUME    = DEFAULT_VOLUME,
   parameter logic [8:0] DEF_AUDIO_DIV = DEFAULT_AUDIO_DIV
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vs_n,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic [1:0] system_scanlines,
   output logic [1:0] system_volume,
   output logic       system_wide_screen,
   output logic       ntscmode,
   output logic [8:0] audio_div,
   output logic       cfg_pending
);

   logic [1:0] sh_scanlines;
   logic [1:0] sh_volume;
   logic       sh_wide;
   logic       sh_ntsc;
   logic [8:0] sh_audio_div;
   logic       wr_mapped;
   logic       commit;

   assign wr_mapped = wr_en && (wr_addr <= REG_AUDIO_HI);

`ifdef VIDEO_CFG_VSYNC_COMMIT_EN
   logic vs_d;
   logic vs_fall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vs_d    <= 1'b1;
         vs_fall <= 1'b0;
      end else begin
         vs_d    <= vs_n;
         vs_fall <= vs_d & ~vs_n;
      end
   end

   assign commit = vs_fall & cfg_pending;
`else
   logic unused_vs_n;
   assign unused_vs_n = vs_n;
   // Pending is high exactly the cycle after a write, so it doubles as commit.
   assign commit = cfg_pending;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_scanlines <= DEF_SCANLINES;
         sh_volume    <= DEF_VOLUME;
         sh_wide      <= 1'b0;
         sh_ntsc      <= 1'b0;
         sh_audio_div <= DEF_AUDIO_DIV;
      end else if (wr_en) begin
         case (wr_addr)
            REG_SCANLINES: sh_scanlines      <= wr_data[1:0];
            REG_VOLUME:    sh_volume         <= wr_data[1:0];
            REG_WIDE:      sh_wide           <= wr_data[0];
            REG_NTSC:      sh_ntsc           <= wr_data[0];
            REG_AUDIO_LO:  sh_audio_div[7:0] <= wr_data;
            REG_AUDIO_HI:  sh_audio_div[8]   <= wr_data[0];
            default: ;
         endcase
      end
   end

   // Commit samples the shadow before any same-cycle write lands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         system_scanlines   <= DEF_SCANLINES;
         system_volume      <= DEF_VOLUME;
         system_wide_screen <= 1'b0;
         ntscmode           <= 1'b0;
         audio_div          <= DEF_AUDIO_DIV;
         cfg_pending        <= 1'b0;
      end else begin
         if (commit) begin
            system_scanlines   <= sh_scanlines;
            system_volume      <= sh_volume;
            system_wide_screen <= sh_wide;
            ntscmode           <= sh_ntsc;
            audio_div          <= sh_audio_div;
         end
         if (wr_mapped)
            cfg_pending <= 1'b1;
         else if (commit)
            cfg_pending <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/video_cfg_ctrl.sv
// ============================================================================
// Module      : video_cfg_ctrl
// Description : MCU byte-stream decoder: OSD forwarding and config writes.
//               Build option VIDEO_CFG_VSYNC_COMMIT_EN defers commit to vsync.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_cfg_ctrl
   import video_cfg_pkg::*;
#(
   parameter logic [1:0] DEF_SCANLINES = DEFAULT_SCANLINES,
   parameter logic [1:0] DEF_VOLUME    = DEFAULT_VOLUME,
   parameter logic [8:0] DEF_AUDIO_DIV = DEFAULT_AUDIO_DIV
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mcu_start,
   input  logic       mcu_strobe,
   input  logic [7:0] mcu_data,
   input  logic       vs_n,
   output logic       osd_start,
   output logic       osd_strobe,
   output logic [7:0] osd_data,
   output logic [1:0] system_scanlines,
   output logic [1:0] system_volume,
   output logic       system_wide_screen,
   output logic       ntscmode,
   output logic [8:0] audio_div,
   output logic       cfg_pending
);

   state_t     state;
   state_t     next_state;
   logic [2:0] ptr;
   logic       cmd_take;
   logic       osd_take;
   logic       ptr_load;
   logic       wr_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // A start strobed together with a byte treats that byte as the command.
   always_comb begin
      next_state = state;
      cmd_take   = 1'b0;
      osd_take   = 1'b0;
      ptr_load   = 1'b0;
      wr_en      = 1'b0;
      if (mcu_start) begin
         cmd_take   = mcu_strobe;
         next_state = mcu_strobe ? cmd_next(mcu_data) : CMD;
      end else if (mcu_strobe) begin
         case (state)
            CMD: begin
               cmd_take   = 1'b1;
               next_state = cmd_next(mcu_data);
            end
            OSD:  osd_take = 1'b1;
            ADDR: begin
               ptr_load   = 1'b1;
               next_state = DATA;
            end
            DATA: wr_en = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr        <= 3'd0;
         osd_start  <= 1'b0;
         osd_strobe <= 1'b0;
         osd_data   <= 8'h00;
      end else begin
         if (ptr_load)
            ptr <= mcu_data[2:0];
         else if (wr_en)
            ptr <= ptr + 3'd1;
         osd_start  <= cmd_take && (mcu_data == CMD_OSD);
         osd_strobe <= osd_take;
         if (osd_take)
            osd_data <= mcu_data;
      end
   end

   video_cfg_regs #(
      .DEF_SCANLINES (DEF_SCANLINES),
      .DEF_VOLUME    (DEF_VOLUME),
      .DEF_AUDIO_DIV (DEF_AUDIO_DIV)
   ) u_regs (
      .clk                (clk),
      .reset              (reset),
      .vs_n               (vs_n),
      .wr_en              (wr_en),
      .wr_addr            (ptr),
      .wr_data            (mcu_data),
      .system_scanlines   (system_scanlines),
      .system_volume      (system_volume),
      .system_wide_screen (system_wide_screen),
      .ntscmode           (ntscmode),
      .audio_div          (audio_div),
      .cfg_pending        (cfg_pending)
   );

endmodule

`default_nettype wire

// File: tb/tb_video_cfg_ctrl.sv
// ============================================================================
// Module      : tb_video_cfg_ctrl
// Description : Directed self-checking bench for video_cfg_ctrl; the vsync
//               commit tests run when VIDEO_CFG_VSYNC_COMMIT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_cfg_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       mcu_start = 1'b0;
   logic       mcu_strobe = 1'b0;
   logic [7:0] mcu_data = 8'h00;
   logic       vs_n = 1'b1;
   logic       osd_start;
   logic       osd_strobe;
   logic [7:0] osd_data;
   logic [1:0] system_scanlines;
   logic [1:0] system_volume;
   logic       system_wide_screen;
   logic       ntscmode;
   logic [8:0] audio_div;
   logic       cfg_pending;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   video_cfg_ctrl dut (
      .clk                (clk),
      .reset              (reset),
      .mcu_start          (mcu_start),
      .mcu_strobe         (mcu_strobe),
      .mcu_data           (mcu_data),
      .vs_n               (vs_n),
      .osd_start          (osd_start),
      .osd_strobe         (osd_strobe),
      .osd_data           (osd_data),
      .system_scanlines   (system_scanlines),
      .system_volume      (system_volume),
      .system_wide_screen (system_wide_screen),
      .ntscmode           (ntscmode),
      .audio_div          (audio_div),
      .cfg_pending        (cfg_pending)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, pass the rising edge, settle, release inputs.
   task automatic cyc(input logic st, input logic sb, input logic [7:0] d);
      mcu_start  = st;
      mcu_strobe = sb;
      mcu_data   = d;
      @(posedge clk);
      #1;
      mcu_start  = 1'b0;
      mcu_strobe = 1'b0;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_osd_start"},  {31'd0, osd_start},          32'd0);
      chk({tag, "_osd_strobe"}, {31'd0, osd_strobe},         32'd0);
      chk({tag, "_osd_data"},   {24'd0, osd_data},           32'd0);
      chk({tag, "_scan"},       {30'd0, system_scanlines},   32'd0);
      chk({tag, "_vol"},        {30'd0, system_volume},      32'd3);
      chk({tag, "_wide"},       {31'd0, system_wide_screen}, 32'd0);
      chk({tag, "_ntsc"},       {31'd0, ntscmode},           32'd0);
      chk({tag, "_audio"},      {23'd0, audio_div},          32'd327);
      chk({tag, "_pending"},    {31'd0, cfg_pending},        32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_reset_values("rst");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Strobe in IDLE must be ignored.
      cyc(1'b0, 1'b1, 8'h01);
      chk("idle_no_osd_start", {31'd0, osd_start}, 32'd0);
      chk("idle_no_osd_strobe", {31'd0, osd_strobe}, 32'd0);

      // OSD forwarding.
      cyc(1'b1, 1'b1, 8'h01);
      chk("osd_start_pulse", {31'd0, osd_start}, 32'd1);
      cyc(1'b0, 1'b1, 8'hA5);
      chk("osd_start_cleared", {31'd0, osd_start}, 32'd0);
      chk("osd_strobe_a5", {31'd0, osd_strobe}, 32'd1);
      chk("osd_data_a5", {24'd0, osd_data}, 32'hA5);
      cyc(1'b0, 1'b0, 8'hEE);
      chk("osd_strobe_gap", {31'd0, osd_strobe}, 32'd0);
      chk("osd_data_hold", {24'd0, osd_data}, 32'hA5);
      cyc(1'b0, 1'b1, 8'h3C);
      chk("osd_strobe_3c", {31'd0, osd_strobe}, 32'd1);
      chk("osd_data_3c", {24'd0, osd_data}, 32'h3C);

`ifdef VIDEO_CFG_VSYNC_COMMIT_EN
      // Atomic audio_div update committed on vsync.
      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b1, 8'h02);
      cyc(1'b0, 1'b1, 8'h04);
      cyc(1'b0, 1'b1, 8'h48);
      cyc(1'b0, 1'b1, 8'h01);
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      chk("aud_hold_before_vs", {23'd0, audio_div}, 32'd327);
      chk("aud_pending", {31'd0, cfg_pending}, 32'd1);
      vs_n = 1'b0;
      cyc(1'b0, 1'b0, 8'h00);
      chk("aud_edge_cycle", {23'd0, audio_div}, 32'd327);
      cyc(1'b0, 1'b0, 8'h00);
      chk("aud_committed", {23'd0, audio_div}, 32'h148);
      chk("aud_pending_clr", {31'd0, cfg_pending}, 32'd0);
      cyc(1'b0, 1'b0, 8'h00);
      vs_n = 1'b1;
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);

      // Collision: scanlines=3 pending, volume=1 written in the commit cycle.
      cyc(1'b1, 1'b1, 8'h02);
      cyc(1'b0, 1'b1, 8'h00);
      cyc(1'b0, 1'b1, 8'h03);
      cyc(1'b1, 1'b1, 8'h02);
      cyc(1'b0, 1'b1, 8'h01);
      vs_n = 1'b0;
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b1, 8'h01);
      chk("col_scan_old_shadow", {30'd0, system_scanlines}, 32'd3);
      chk("col_vol_old_shadow", {30'd0, system_volume}, 32'd3);
      chk("col_pending_kept", {31'd0, cfg_pending}, 32'd1);
      vs_n = 1'b1;
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      vs_n = 1'b0;
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      chk("col_vol_next_vs", {30'd0, system_volume}, 32'd1);
      chk("col_pending_clr", {31'd0, cfg_pending}, 32'd0);
      vs_n = 1'b1;
      cyc(1'b0, 1'b0, 8'h00);

      // Bad command: discard, no OSD, no register change.
      cyc(1'b1, 1'b1, 8'h7F);
      chk("bad_no_osd_start", {31'd0, osd_start}, 32'd0);
      cyc(1'b0, 1'b1, 8'h55);
      chk("bad_no_osd_strobe", {31'd0, osd_strobe}, 32'd0);
      chk("bad_no_pending", {31'd0, cfg_pending}, 32'd0);
      vs_n = 1'b0;
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      chk("bad_vol_same", {30'd0, system_volume}, 32'd1);
      chk("bad_scan_same", {30'd0, system_scanlines}, 32'd3);
      vs_n = 1'b1;
      cyc(1'b0, 1'b0, 8'h00);
`else
      // Immediate commit of audio_div low byte.
      cyc(1'b1, 1'b1, 8'h02);
      cyc(1'b0, 1'b1, 8'h04);
      cyc(1'b0, 1'b1, 8'h48);
      chk("imm_aud_not_yet", {23'd0, audio_div}, 32'd327);
      chk("imm_pending_set", {31'd0, cfg_pending}, 32'd1);
      cyc(1'b0, 1'b0, 8'h00);
      chk("imm_aud_commit", {23'd0, audio_div}, 32'h148);
      cyc(1'b0, 1'b0, 8'h00);
      chk("imm_pending_pulse", {31'd0, cfg_pending}, 32'd0);

      // Pointer wrap from address 7.
      cyc(1'b1, 1'b1, 8'h02);
      cyc(1'b0, 1'b1, 8'h07);
      cyc(1'b0, 1'b1, 8'h00);
      chk("wrap_addr7_ignored", {31'd0, cfg_pending}, 32'd0);
      cyc(1'b0, 1'b1, 8'h09);
      chk("wrap_scan_not_yet", {30'd0, system_scanlines}, 32'd0);
      cyc(1'b0, 1'b1, 8'h02);
      chk("wrap_scan_1", {30'd0, system_scanlines}, 32'd1);
      chk("wrap_vol_not_yet", {30'd0, system_volume}, 32'd3);
      cyc(1'b0, 1'b0, 8'h00);
      chk("wrap_vol_2", {30'd0, system_volume}, 32'd2);

      // Bad command.
      cyc(1'b1, 1'b1, 8'h7F);
      cyc(1'b0, 1'b1, 8'h55);
      chk("bad_no_osd_strobe", {31'd0, osd_strobe}, 32'd0);
      cyc(1'b0, 1'b0, 8'h00);
      chk("bad_no_pending", {31'd0, cfg_pending}, 32'd0);
      chk("bad_scan_same", {30'd0, system_scanlines}, 32'd1);
`endif

      // Abort mid-DATA with a new OSD transaction.
      cyc(1'b1, 1'b1, 8'h02);
      cyc(1'b0, 1'b1, 8'h00);
      cyc(1'b1, 1'b1, 8'h01);
      chk("abort_osd_start", {31'd0, osd_start}, 32'd1);
      cyc(1'b0, 1'b1, 8'h11);
      chk("abort_osd_strobe", {31'd0, osd_strobe}, 32'd1);
      chk("abort_osd_data", {24'd0, osd_data}, 32'h11);

      // Reset during DATA after a shadow write, before any commit.
      cyc(1'b1, 1'b1, 8'h02);
      cyc(1'b0, 1'b1, 8'h00);
      cyc(1'b0, 1'b1, 8'h02);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_values("mid_rst");
      @(negedge clk);
      reset = 1'b0;
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      chk("post_rst_scan", {30'd0, system_scanlines}, 32'd0);
      chk("post_rst_pending", {31'd0, cfg_pending}, 32'd0);
      cyc(1'b0, 1'b1, 8'h01);
      chk("post_rst_idle", {31'd0, osd_start}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
